// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: IF-stage PC owner with in-flight prediction queue, mispredict redirect and resolution statistics
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        is_branch_if,
  input  logic        is_jump_if,
  input  logic        predict_taken,
  input  logic        use_predicted,
  input  logic [31:0] predicted_pc,
  input  logic        resolve_ex,
  input  logic        is_branch_ex,
  input  logic        is_jump_ex,
  input  logic [31:0] pc_ex,
  input  logic [31:0] branch_pc_ex,
  input  logic        cmp_out_ex,
  output logic [31:0] pc_if,
  output logic        queue_full,
  output logic        flush,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count,
  output logic        protocol_err
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] pc_q, pc_d;
  logic [31:0] qpc_q [DEPTH];
  logic [31:0] qpred_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0] cnt_q;
  logic [31:0] bcnt_q, mcnt_q;
  logic perr_q;
  logic empty, actual_taken, tag_bad, flush_cond, fetch_advance, push, pop;
  logic [31:0] actual_next, pred_next;
  logic unused_predict_taken;
  // The taken bit is already folded into predicted_pc by the predictor
  assign unused_predict_taken = predict_taken;
  assign queue_full = cnt_q == (AW+1)'(DEPTH);
  assign pc_if = pc_q;
  assign flush = flush_cond;
  assign branch_count = bcnt_q;
  assign mispredict_count = mcnt_q;
  assign protocol_err = perr_q;
  // Compare the resolving instruction with the oldest prediction and pick the next fetch PC
  always_comb begin
    empty = cnt_q == '0;
    actual_taken = is_jump_ex | (is_branch_ex & cmp_out_ex);
    actual_next = actual_taken ? branch_pc_ex : pc_ex + 32'd4;
    tag_bad = empty | (qpc_q[head_q] != pc_ex);
    flush_cond = resolve_ex & (tag_bad | (qpred_q[head_q] != actual_next));
    fetch_advance = ~stall_if & ~queue_full & ~flush_cond;
    pred_next = use_predicted ? predicted_pc : pc_q + 32'd4;
    push = fetch_advance & (is_branch_if | is_jump_if);
    pop = resolve_ex & ~empty;
    pc_d = flush_cond ? actual_next : fetch_advance ? pred_next : pc_q;
  end
  // Queue storage; a push never coincides with a flush, so writes need no squash
  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[tail_q] <= pc_q;
      qpred_q[tail_q] <= pred_next;
    end
  end
  // PC, queue pointers, statistics and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
      perr_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (resolve_ex && bcnt_q != '1) bcnt_q <= bcnt_q + 32'd1;
      if (flush_cond) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q <= '0;
        if (mcnt_q != '1) mcnt_q <= mcnt_q + 32'd1;
        if (tag_bad) perr_q <= 1'b1;
      end else begin
        if (push) tail_q <= tail_q + AW'(1);
        if (pop) head_q <= head_q + AW'(1);
        cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule
